// File: rtl/exec_stage_pkg.sv
// Shared definitions for the execute stage: width defaults, opcodes and FSM state encoding.
// The MUL state exists only when EXEC_STAGE_MUL_EN is defined.
package exec_pkg;

  localparam int unsigned DEFAULT_DATA_W = 32;
  localparam int unsigned DEFAULT_ADDR_W = 2;

  typedef logic [2:0] opcode_t;

  localparam opcode_t OP_ADD  = 3'd0;
  localparam opcode_t OP_SUB  = 3'd1;
  localparam opcode_t OP_AND  = 3'd2;
  localparam opcode_t OP_OR   = 3'd3;
  localparam opcode_t OP_XOR  = 3'd4;
  localparam opcode_t OP_SLT  = 3'd5;
  localparam opcode_t OP_MUL  = 3'd6;
  localparam opcode_t OP_PASS = 3'd7;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
`ifdef EXEC_STAGE_MUL_EN
  localparam state_t ST_MUL  = 2'd1;
`endif
  localparam state_t ST_WB   = 2'd2;

  function automatic logic is_mul(input opcode_t op);
    return op == OP_MUL;
  endfunction

endpackage

// File: rtl/exec_stage_seq_mul.sv
// Sequential shift-add multiplier: DATA_W iterations after start, low DATA_W product bits.
// done is raised during the last iteration; product then already holds the final sum.
module seq_mul #(
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              done,
  output logic [DATA_W-1:0] product
);

  localparam int unsigned CW = $clog2(DATA_W + 1);

  logic [CW-1:0]     cnt;
  logic [DATA_W-1:0] mcand;
  logic [DATA_W-1:0] mplier;
  logic [DATA_W-1:0] acc;
  logic [DATA_W-1:0] acc_nxt;

  always_comb begin
    acc_nxt = acc;
    if (mplier[0]) acc_nxt = acc + mcand;
  end

  // Exposing the next accumulator lets the caller capture the result on the final iteration edge.
  assign done    = (cnt == CW'(1));
  assign product = acc_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt    <= '0;
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
    end else if (start) begin
      cnt    <= CW'(DATA_W);
      mcand  <= a;
      mplier <= b;
      acc    <= '0;
    end else if (cnt != '0) begin
      cnt    <= cnt - CW'(1);
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      acc    <= acc_nxt;
    end
  end

endmodule

// File: rtl/exec_stage.sv
// Execute stage: single-issue ALU with register-bank writeback pulse.
// Optional sequential multiplier enabled by EXEC_STAGE_MUL_EN; otherwise op 6 raises err_illegal.
module exec_stage
  import exec_pkg::*;
#(
  parameter int unsigned DATA_W = DEFAULT_DATA_W,
  parameter int unsigned ADDR_W = DEFAULT_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        op,
  input  logic [ADDR_W-1:0] rd,
  input  logic [DATA_W-1:0] rdata1,
  input  logic [DATA_W-1:0] rdata2,
  output logic              write,
  output logic [ADDR_W-1:0] wa,
  output logic [DATA_W-1:0] wdata,
  output logic              err_illegal
);

  state_t            state;
  logic              accept;
  logic [DATA_W-1:0] alu_res;

  assign in_ready = (state == ST_IDLE);
  assign accept   = in_valid && in_ready;
  assign write    = (state == ST_WB);

  always_comb begin
    alu_res = '0;
    case (op)
      OP_ADD:  alu_res = rdata1 + rdata2;
      OP_SUB:  alu_res = rdata1 - rdata2;
      OP_AND:  alu_res = rdata1 & rdata2;
      OP_OR:   alu_res = rdata1 | rdata2;
      OP_XOR:  alu_res = rdata1 ^ rdata2;
      OP_SLT:  alu_res = {{(DATA_W-1){1'b0}}, ($signed(rdata1) < $signed(rdata2))};
      OP_PASS: alu_res = rdata1;
      default: alu_res = '0;
    endcase
  end

`ifdef EXEC_STAGE_MUL_EN
  logic              mul_start;
  logic              mul_done;
  logic [DATA_W-1:0] mul_prod;
  logic [ADDR_W-1:0] rd_q;

  assign mul_start = accept && is_mul(op);

  seq_mul #(
    .DATA_W(DATA_W)
  ) u_seq_mul (
    .clk    (clk),
    .rst    (rst),
    .start  (mul_start),
    .a      (rdata1),
    .b      (rdata2),
    .done   (mul_done),
    .product(mul_prod)
  );
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      wa          <= '0;
      wdata       <= '0;
      err_illegal <= 1'b0;
`ifdef EXEC_STAGE_MUL_EN
      rd_q        <= '0;
`endif
    end else begin
      err_illegal <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            if (is_mul(op)) begin
`ifdef EXEC_STAGE_MUL_EN
              // wa must hold its old value until writeback, so the destination waits in rd_q.
              state <= ST_MUL;
              rd_q  <= rd;
`else
              err_illegal <= 1'b1;
`endif
            end else begin
              state <= ST_WB;
              wa    <= rd;
              wdata <= alu_res;
            end
          end
        end
`ifdef EXEC_STAGE_MUL_EN
        ST_MUL: begin
          if (mul_done) begin
            state <= ST_WB;
            wa    <= rd_q;
            wdata <= mul_prod;
          end
        end
`endif
        ST_WB:   state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_exec_stage.sv
// Self-checking bench for exec_stage: cycle-level reference model plus directed literal checks.
// Works for both builds (EXEC_STAGE_MUL_EN defined or not).
module tb_exec_stage;

  localparam int DW = 32;
  localparam int AW = 2;

  localparam logic [2:0] ADD = 3'd0, SUB = 3'd1, AND_ = 3'd2, OR_ = 3'd3;
  localparam logic [2:0] XOR_ = 3'd4, SLT = 3'd5, MULOP = 3'd6, PASS = 3'd7;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [2:0]    op = '0;
  logic [AW-1:0] rd = '0;
  logic [DW-1:0] rdata1 = '0;
  logic [DW-1:0] rdata2 = '0;
  logic          write;
  logic [AW-1:0] wa;
  logic [DW-1:0] wdata;
  logic          err_illegal;

  exec_stage #(
    .DATA_W(DW),
    .ADDR_W(AW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .op         (op),
    .rd         (rd),
    .rdata1     (rdata1),
    .rdata2     (rdata2),
    .write      (write),
    .wa         (wa),
    .wdata      (wdata),
    .err_illegal(err_illegal)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model state, indexed by bench cycle number t.
  int            t = 0;
  int            busy_until = 0;
  int            wr_cycle = -1;
  int            err_cycle = -1;
  logic [AW-1:0] wr_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic [AW-1:0] cur_wa = '0;
  logic [DW-1:0] cur_wdata = '0;
  int            writes_seen = 0;

`ifdef EXEC_STAGE_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif

  function automatic logic [DW-1:0] ref_res(input logic [2:0] o, input logic [DW-1:0] a,
                                            input logic [DW-1:0] b);
    logic [2*DW-1:0] full;
    case (o)
      ADD:     return a + b;
      SUB:     return a - b;
      AND_:    return a & b;
      OR_:     return a | b;
      XOR_:    return a ^ b;
      SLT:     return ($signed(a) < $signed(b)) ? 1 : 0;
      MULOP: begin
        full = {{DW{1'b0}}, a} * {{DW{1'b0}}, b};
        return full[DW-1:0];
      end
      default: return a;
    endcase
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, t);
    end
  endtask

  // One bench cycle: compare outputs at the negedge, then drive inputs for the next rising edge.
  task automatic step(input bit v, input logic [2:0] o, input logic [AW-1:0] r,
                      input logic [DW-1:0] a, input logic [DW-1:0] b, input bit rs);
    bit ready_e;
    @(negedge clk);
    t++;
    ready_e = (t > busy_until);
    if (t == wr_cycle) begin
      cur_wa    = wr_addr;
      cur_wdata = wr_data;
    end
    if (write === 1'b1) writes_seen++;
    check("in_ready", in_ready, ready_e);
    check("write", write, t == wr_cycle);
    check("err_illegal", err_illegal, t == err_cycle);
    check("wa", wa, cur_wa);
    check("wdata", wdata, cur_wdata);

    in_valid = v; op = o; rd = r; rdata1 = a; rdata2 = b; rst = rs;
    if (rs) begin
      busy_until = t;
      wr_cycle   = -1;
      err_cycle  = -1;
      cur_wa     = '0;
      cur_wdata  = '0;
    end else if (v && ready_e) begin
      if (o == MULOP && !MUL_EN) begin
        err_cycle  = t + 1;
        busy_until = t;
      end else begin
        wr_cycle   = (o == MULOP) ? t + DW + 1 : t + 1;
        busy_until = wr_cycle;
        wr_addr    = r;
        wr_data    = ref_res(o, a, b);
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, ADD, '0, '0, '0, 1'b0);
  endtask

  function automatic logic [DW-1:0] rand_operand();
    case ($urandom_range(0, 7))
      0: return '0;
      1: return '1;
      2: return 32'h8000_0000;
      3: return 32'h7FFF_FFFF;
      4: return 32'h0000_0001;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    step(1'b0, ADD, '0, '0, '0, 1'b1);
    step(1'b0, ADD, '0, '0, '0, 1'b1);
    step(1'b0, ADD, '0, '0, '0, 1'b0);
    check("rst_ready", in_ready, 1'b1);
    check("rst_wdata", wdata, 32'h0);

    // ADD
    step(1'b1, ADD, 2'd1, 32'h0014_5601, 32'h0000_0987, 1'b0);
    step(1'b0, ADD, '0, '0, '0, 1'b0);
    check("add_write", write, 1'b1);
    check("add_wa", wa, 2'd1);
    check("add_wdata", wdata, 32'h0014_5F88);

    // SUB then SLT
    step(1'b1, SUB, 2'd2, 32'd5, 32'd7, 1'b0);
    step(1'b0, ADD, '0, '0, '0, 1'b0);
    check("sub_wdata", wdata, 32'hFFFF_FFFE);
    step(1'b1, SLT, 2'd0, 32'hFFFF_FFFF, 32'd1, 1'b0);
    step(1'b0, ADD, '0, '0, '0, 1'b0);
    check("slt_wdata", wdata, 32'h0000_0001);

    // Back-to-back: second request held until accepted
    step(1'b1, ADD, 2'd2, 32'd1, 32'd2, 1'b0);
    step(1'b1, ADD, 2'd3, 32'd3, 32'd4, 1'b0);
    check("b2b_w1", wdata, 32'd3);
    step(1'b1, ADD, 2'd3, 32'd3, 32'd4, 1'b0);
    check("b2b_ready", write, 1'b0);
    step(1'b0, ADD, '0, '0, '0, 1'b0);
    check("b2b_w2", {31'd0, write, 30'd0, wa, wdata}, {31'd0, 1'b1, 30'd0, 2'd3, 32'd7});

`ifdef EXEC_STAGE_MUL_EN
    step(1'b1, MULOP, 2'd3, 32'd7, 32'd6, 1'b0);
    idle(32);
    check("mul_busy", in_ready, 1'b0);
    step(1'b0, ADD, '0, '0, '0, 1'b0);
    check("mul_write", write, 1'b1);
    check("mul_res", {wa, wdata}, {2'd3, 32'h0000_002A});
    step(1'b1, MULOP, 2'd1, 32'h0001_0000, 32'h0001_0000, 1'b0);
    idle(33);
    check("mul_wrap", wdata, 32'h0);

    // Reset mid-MUL: no write may ever appear for the aborted op
    step(1'b1, MULOP, 2'd2, 32'd9, 32'd9, 1'b0);
    idle(9);
    writes_seen = 0;
    step(1'b0, ADD, '0, '0, '0, 1'b1);
    step(1'b0, ADD, '0, '0, '0, 1'b0);
    step(1'b0, ADD, '0, '0, '0, 1'b0);
    check("rst_mul_ready", in_ready, 1'b1);
    idle(40);
    check("rst_mul_nowrite", writes_seen, 0);
`else
    step(1'b1, MULOP, 2'd1, 32'd7, 32'd6, 1'b0);
    writes_seen = 0;
    step(1'b0, ADD, '0, '0, '0, 1'b0);
    check("ill_err", err_illegal, 1'b1);
    check("ill_ready", in_ready, 1'b1);
    check("ill_nowrite", writes_seen, 0);
    step(1'b1, ADD, 2'd2, 32'd10, 32'd20, 1'b0);
    step(1'b0, ADD, '0, '0, '0, 1'b0);
    check("ill_add", {31'd0, write, 30'd0, wa, wdata}, {31'd0, 1'b1, 30'd0, 2'd2, 32'd30});
`endif

    // Randomized traffic, including occasional resets
    for (int i = 0; i < 1500; i++) begin
      bit rs;
      rs = ($urandom_range(0, 99) == 0);
      step($urandom_range(0, 9) < 7, 3'($urandom_range(0, 7)), AW'($urandom_range(0, 3)),
           rand_operand(), rand_operand(), rs);
    end
    idle(40);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/exec_stage.md
EXEC_STAGE -- requirements
Module: exec_stage

Interface
REQ-001 Parameter DATA_W, 32, operand/result width.
REQ-002 Parameter ADDR_W, 2, register address width (4-entry register bank).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 in_valid  input  1  operation request valid.
REQ-006 in_ready  output  1  stage can accept a request.
REQ-007 op  input  3  opcode.
REQ-008 rd  input  ADDR_W  destination register address.
REQ-009 rdata1  input  DATA_W  operand A, from register bank read port 1.
REQ-010 rdata2  input  DATA_W  operand B, from register bank read port 2.
REQ-011 write  output  1  register bank write enable, one-cycle pulse.
REQ-012 wa  output  ADDR_W  register bank write address.
REQ-013 wdata  output  DATA_W  register bank write data.
REQ-014 err_illegal  output  1  one-cycle pulse on an unsupported opcode.

Function
REQ-015 Opcodes: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLT (signed A<B -> 1, else 0), 6 MUL (low DATA_W bits of A*B), 7 PASS (A).
REQ-016 Accept occurs when in_valid && in_ready; op, rd, rdata1 and rdata2 are sampled on that edge only.
REQ-017 FSM states: IDLE, MUL, WB; in_ready = 1 only in IDLE.
REQ-018 IDLE + accept of a non-MUL op -> WB; the result is registered into wdata, and rd into wa.
REQ-019 IDLE + accept of MUL -> MUL; a shift-add multiplier runs exactly DATA_W iterations, one per cycle, then -> WB.
REQ-020 WB: write = 1 for exactly one cycle, then -> IDLE.
REQ-021 Latency, for accept at cycle N: a non-MUL op writes at N+1; MUL writes at N+DATA_W+1 (N+33 for DATA_W=32).
REQ-022 Minimum issue interval is 2 cycles; requests are held off by in_ready = 0 and never dropped.
REQ-023 All arithmetic is modulo 2^DATA_W; overflow wraps silently, and no carry or flag output exists.
REQ-024 wa and wdata hold their last values outside WB; write = 0 in IDLE and MUL.
REQ-025 in_valid while not ready has no effect, and the operand inputs are ignored during MUL.

Reset
REQ-026 While rst = 1: state = IDLE, write = 0, err_illegal = 0, wa = 0, wdata = 0, multiplier counter and accumulators = 0.
REQ-027 Reset asserted during MUL or WB aborts the operation; no write pulse is issued for it, including after rst deasserts.
REQ-028 in_ready = 1 in the first cycle after rst deasserts.

Configuration
REQ-029 Macro EXEC_STAGE_MUL_EN: when defined, MUL is supported as in REQ-019/021.
REQ-030 When EXEC_STAGE_MUL_EN is undefined: no multiplier logic exists, and the MUL state is absent.
REQ-031 Under REQ-030, accepting op 6 causes err_illegal = 1 at N+1, write = 0, and a return to IDLE (in_ready = 1 at N+1).

Structure
REQ-032 Shared package exec_pkg holds the opcode constants, the FSM state typedef, DATA_W and ADDR_W defaults.
REQ-033 The multiplier is a sub-module seq_mul (start/done, iteration counter, shift-add datapath), instantiated only under EXEC_STAGE_MUL_EN.

Verification
REQ-034 ADD: rdata1 = 0x00145601, rdata2 = 0x00000987, rd = 1 -> write at N+1, wa = 1, wdata = 0x00145F88.
REQ-035 SUB then SLT: 5-7 -> wdata = 0xFFFFFFFE; SLT with A = 0xFFFFFFFF, B = 1 -> wdata = 0x00000001.
REQ-036 MUL: 7*6, rd = 3 -> in_ready = 0 for N+1..N+33; write only at N+33, wdata = 0x0000002A; also 0x00010000*0x00010000 -> 0x00000000.
REQ-037 Back-to-back: in_valid held high with two ADDs -> accepts at N and N+2; writes at N+1 and N+3; no lost request.
REQ-038 Reset mid-MUL: assert rst at N+10 -> write never pulses for that op; in_ready = 1 the cycle after release.
REQ-039 Build without EXEC_STAGE_MUL_EN: op 6 -> err_illegal pulse at N+1, no write; a following ADD completes normally.
